// File: rtl/apsk_demapper.sv
// apsk_demapper: min-distance APSK hard decision, bits packed LSB-first; define APSK_DEMAPPER_DISTANCE_OUT_EN for min_distance outputs
module apsk_demapper #(
  parameter int DATA_WIDTH = 16,
  parameter int BITS_PER_SYMBOL_WIDTH = 4,
  parameter int DATA_IN_TDATA_WIDTH = 32,
  parameter int DATA_OUT_TDATA_WIDTH = 32,
  parameter int LUT_DATA_LOAD_TDATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                                 data_in_aclk,
  input  logic                                 reset,
  output logic                                 data_in_tready,
  input  logic [DATA_IN_TDATA_WIDTH-1:0]       data_in_tdata,
  input  logic                                 data_in_tlast,
  input  logic                                 data_in_tvalid,
  input  logic                                 data_out_tready,
  output logic [DATA_OUT_TDATA_WIDTH-1:0]      data_out_tdata,
  output logic                                 data_out_tlast,
  output logic                                 data_out_tvalid,
  output logic                                 lut_data_load_tready,
  input  logic [LUT_DATA_LOAD_TDATA_WIDTH-1:0] lut_data_load_tdata,
  input  logic                                 lut_data_load_tlast,
  input  logic                                 lut_data_load_tvalid,
  input  logic [BITS_PER_SYMBOL_WIDTH-1:0]     bits_per_symbol
`ifdef APSK_DEMAPPER_DISTANCE_OUT_EN
  ,
  output logic [2*DATA_WIDTH+2:0]              min_distance,
  output logic                                 min_distance_valid
`endif
);
  localparam int OW = DATA_OUT_TDATA_WIDTH;
  localparam int AW = OW + 8;
  localparam int CW = $clog2(AW + 1);
  localparam int SW = 2 * DATA_WIDTH + 3;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, EMIT} state_t;
  state_t state, state_nx;
  logic [LUT_DATA_LOAD_TDATA_WIDTH-1:0] lut [DEPTH];
  logic [ADDRESS_WIDTH-1:0] load_addr, k, idx1, idx2, best_idx;
  logic signed [DATA_WIDTH-1:0] sym_i, sym_q, ie, qe;
  logic sym_last, v1, v2, drain_cnt, emitted, pend2, full;
  logic [BITS_PER_SYMBOL_WIDTH-1:0] bps, eff_bps;
  logic [ADDRESS_WIDTH:0] n_last;
  logic signed [DATA_WIDTH:0] di, dq;
  logic [2*DATA_WIDTH+1:0] sq_i, sq_q;
  logic [SW-1:0] d, best_d;
  logic [AW-1:0] acc, merged;
  logic [CW-1:0] cnt, cnt_sum;
  logic in_hs, out_hs, load_hs;
  assign data_in_tready = state == IDLE && !data_out_tvalid;
  assign lut_data_load_tready = state == IDLE && cnt == '0 && !data_out_tvalid;
  assign in_hs = data_in_tvalid && data_in_tready;
  assign out_hs = data_out_tvalid && data_out_tready;
  assign load_hs = lut_data_load_tvalid && lut_data_load_tready;
  assign eff_bps = (bits_per_symbol == '0 || bits_per_symbol > BITS_PER_SYMBOL_WIDTH'(8)) ?
                   BITS_PER_SYMBOL_WIDTH'(1) : bits_per_symbol;
  assign n_last = ((ADDRESS_WIDTH + 1)'(1) << bps) - 1'b1;
  assign ie = lut[k][LUT_DATA_LOAD_TDATA_WIDTH-1 -: DATA_WIDTH];
  assign qe = lut[k][DATA_WIDTH-1:0];
  assign sq_i = di * di;
  assign sq_q = dq * dq;
  assign merged = acc | (AW'(best_idx) << cnt);
  assign cnt_sum = cnt + CW'(bps);
  assign full = cnt_sum >= CW'(OW);
  // Constellation table write port; contents intentionally survive reset
  always_ff @(posedge data_in_aclk)
    if (load_hs) lut[load_addr] <= lut_data_load_tdata;
  // Load address walks up and restarts on tlast (natural wrap past the last entry)
  always_ff @(posedge data_in_aclk)
    if (reset) load_addr <= '0;
    else if (load_hs) load_addr <= lut_data_load_tlast ? '0 : load_addr + 1'b1;
  // State register
  always_ff @(posedge data_in_aclk)
    state <= reset ? IDLE : state_nx;
  // Next state: EMIT leaves once its words (if any) have all been taken
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_hs ? SEARCH : IDLE;
      SEARCH:  state_nx = {1'b0, k} == n_last ? DRAIN : SEARCH;
      DRAIN:   state_nx = drain_cnt ? EMIT : DRAIN;
      default: state_nx = (!emitted ? !(full || sym_last) : (out_hs && !pend2)) ? IDLE : EMIT;
    endcase
  end
  // Distance pipeline: differences, then squared magnitude
  always_ff @(posedge data_in_aclk) begin
    idx1 <= k;
    di <= {sym_i[DATA_WIDTH-1], sym_i} - {ie[DATA_WIDTH-1], ie};
    dq <= {sym_q[DATA_WIDTH-1], sym_q} - {qe[DATA_WIDTH-1], qe};
    idx2 <= idx1;
    d <= {1'b0, sq_i} + {1'b0, sq_q};
  end
  // Symbol capture, search sequencing, strict-less comparator and bit packing
  always_ff @(posedge data_in_aclk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      k <= '0;
      drain_cnt <= 1'b0;
      emitted <= 1'b0;
      pend2 <= 1'b0;
      sym_last <= 1'b0;
      acc <= '0;
      cnt <= '0;
      data_out_tvalid <= 1'b0;
      data_out_tlast <= 1'b0;
      data_out_tdata <= '0;
    end else begin
      if (in_hs) begin
        sym_i <= data_in_tdata[DATA_IN_TDATA_WIDTH-1 -: DATA_WIDTH];
        sym_q <= data_in_tdata[DATA_WIDTH-1:0];
        sym_last <= data_in_tlast;
        bps <= eff_bps;
        k <= '0;
        best_d <= '1;
        emitted <= 1'b0;
      end
      if (state == SEARCH) k <= k + 1'b1;
      v1 <= state == SEARCH;
      v2 <= v1;
      if (v2 && d < best_d) begin
        best_d <= d;
        best_idx <= idx2;
      end
      drain_cnt <= state == DRAIN && !drain_cnt;
      if (out_hs) begin
        data_out_tvalid <= pend2;
        if (pend2) begin
          data_out_tdata <= acc[OW-1:0];
          data_out_tlast <= 1'b1;
          acc <= '0;
          cnt <= '0;
          pend2 <= 1'b0;
        end
      end
      if (state == EMIT && !emitted) begin
        emitted <= 1'b1;
        if (full) begin
          data_out_tdata <= merged[OW-1:0];
          data_out_tvalid <= 1'b1;
          data_out_tlast <= sym_last && cnt_sum == CW'(OW);
          pend2 <= sym_last && cnt_sum != CW'(OW);
          acc <= merged >> OW;
          cnt <= cnt_sum - CW'(OW);
        end else if (sym_last) begin
          data_out_tdata <= merged[OW-1:0];
          data_out_tvalid <= 1'b1;
          data_out_tlast <= 1'b1;
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt_sum;
        end
      end
    end
  end
`ifdef APSK_DEMAPPER_DISTANCE_OUT_EN
  assign min_distance = best_d;
  assign min_distance_valid = state == EMIT && !emitted;
`endif
endmodule

// File: tb/tb_apsk_demapper.sv
// tb_apsk_demapper: directed checks of table load, decisions, packing, back-pressure and reset
module tb_apsk_demapper;
  logic clk = 1'b0, reset = 1'b1;
  logic data_in_tready, data_in_tlast = 1'b0, data_in_tvalid = 1'b0;
  logic [31:0] data_in_tdata = '0;
  logic data_out_tready = 1'b1, data_out_tlast, data_out_tvalid;
  logic [31:0] data_out_tdata;
  logic lut_data_load_tready, lut_data_load_tlast = 1'b0, lut_data_load_tvalid = 1'b0;
  logic [31:0] lut_data_load_tdata = '0;
  logic [3:0] bits_per_symbol = 4'd2;
  int errors = 0, checks = 0;
  logic [31:0] wq[$];
  logic lq[$];
  always #5 clk = ~clk;

  apsk_demapper dut (
    .data_in_aclk(clk), .reset(reset),
    .data_in_tready(data_in_tready), .data_in_tdata(data_in_tdata),
    .data_in_tlast(data_in_tlast), .data_in_tvalid(data_in_tvalid),
    .data_out_tready(data_out_tready), .data_out_tdata(data_out_tdata),
    .data_out_tlast(data_out_tlast), .data_out_tvalid(data_out_tvalid),
    .lut_data_load_tready(lut_data_load_tready), .lut_data_load_tdata(lut_data_load_tdata),
    .lut_data_load_tlast(lut_data_load_tlast), .lut_data_load_tvalid(lut_data_load_tvalid),
    .bits_per_symbol(bits_per_symbol)
  );

  // Output word collector
  always @(negedge clk)
    if (data_out_tvalid && data_out_tready) begin
      wq.push_back(data_out_tdata);
      lq.push_back(data_out_tlast);
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] i, input logic signed [15:0] q, input logic last, input logic [3:0] b);
    int n = 0;
    data_in_tdata = {i, q};
    data_in_tlast = last;
    bits_per_symbol = b;
    data_in_tvalid = 1'b1;
    while (data_in_tready !== 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n < 3000) begin
      @(posedge clk); #1;
    end else check("send_timeout", 32'(n), 32'd0);
    data_in_tvalid = 1'b0;
    data_in_tlast = 1'b0;
  endtask

  task automatic load(input logic [31:0] pts[$]);
    foreach (pts[j]) begin
      int n = 0;
      lut_data_load_tdata = pts[j];
      lut_data_load_tlast = j == pts.size() - 1;
      lut_data_load_tvalid = 1'b1;
      while (lut_data_load_tready !== 1'b1 && n < 3000) begin
        @(posedge clk); #1; n++;
      end
      if (n < 3000) begin
        @(posedge clk); #1;
      end else check("load_timeout", 32'(n), 32'd0);
    end
    lut_data_load_tvalid = 1'b0;
    lut_data_load_tlast = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    int c = 0;
    while (wq.size() < n && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(wq.size()), 32'(n));
  endtask

  task automatic pop_check(input string tag, input logic [31:0] w, input logic l);
    if (wq.size() > 0) begin
      check({tag, "_data"}, wq.pop_front(), w);
      check({tag, "_last"}, {31'd0, lq.pop_front()}, {31'd0, l});
    end else check({tag, "_missing"}, 32'd0, 32'd1);
  endtask

  task automatic frame_qpsk();
    for (int j = 0; j < 16; j++)
      send((j % 4) & 1 ? -16'sd990 : 16'sd990, (j % 4) & 2 ? -16'sd990 : 16'sd990, j == 15, 4'd2);
  endtask

  task automatic frame_bits(input logic [31:0] w, input logic [3:0] b);
    for (int j = 0; j < 32; j++)
      send(w[j] ? -16'sd990 : 16'sd990, 16'sd990, j == 31, b);
  endtask

  initial begin
    logic [31:0] qpsk[$], psk8[$], tie[$], t0;
    logic l0, stable, in_ok, lut_ok;
    int c;
    qpsk = '{{16'sd1000, 16'sd1000}, {-16'sd1000, 16'sd1000}, {16'sd1000, -16'sd1000}, {-16'sd1000, -16'sd1000}};
    for (int j = 0; j < 8; j++) psk8.push_back({16'(j * 1000), 16'd0});
    tie = '{32'd0, 32'd0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, data_out_tvalid}, 32'd0);
    check("rst_out_last", {31'd0, data_out_tlast}, 32'd0);
    check("rst_out_data", data_out_tdata, 32'd0);
    check("rst_in_ready", {31'd0, data_in_tready}, 32'd1);
    check("rst_lut_ready", {31'd0, lut_data_load_tready}, 32'd1);
    reset = 1'b0;

    load(qpsk);
    frame_qpsk();
    wait_words("qpsk", 1);
    pop_check("qpsk", 32'hE4E4E4E4, 1'b1);

    load(psk8);
    for (int j = 0; j < 11; j++) send(16'sd5010, 16'sd0, j == 10, 4'd3);
    wait_words("psk8", 2);
    pop_check("psk8_w0", 32'h6DB6DB6D, 1'b0);
    pop_check("psk8_w1", 32'h00000001, 1'b1);

    load(tie);
    for (int j = 0; j < 32; j++) send(16'sd0, 16'sd0, j == 31, 4'd1);
    c = 0;
    while (data_out_tvalid !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    check("tie_latency", 32'(c), 32'd5);
    wait_words("tie", 1);
    pop_check("tie", 32'h00000000, 1'b1);

    load(psk8);
    data_out_tready = 1'b0;
    for (int j = 0; j < 11; j++) send(16'sd5010, 16'sd0, j == 10, 4'd3);
    c = 0;
    while (data_out_tvalid !== 1'b1 && c < 50) begin
      @(posedge clk); #1; c++;
    end
    t0 = data_out_tdata;
    l0 = data_out_tlast;
    stable = 1'b1;
    in_ok = 1'b1;
    lut_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      stable &= data_out_tvalid === 1'b1 && data_out_tdata === t0 && data_out_tlast === l0;
      in_ok &= data_in_tready === 1'b0;
      lut_ok &= lut_data_load_tready === 1'b0;
    end
    check("bp_word", t0, 32'h6DB6DB6D);
    check("bp_stable", {31'd0, stable}, 32'd1);
    check("bp_in_ready_low", {31'd0, in_ok}, 32'd1);
    check("bp_lut_ready_low", {31'd0, lut_ok}, 32'd1);
    data_out_tready = 1'b1;
    wait_words("bp", 2);
    pop_check("bp_w0", 32'h6DB6DB6D, 1'b0);
    pop_check("bp_w1", 32'h00000001, 1'b1);

    load(qpsk);
    send(16'sd990, 16'sd990, 1'b0, 4'd8);
    send(16'sd990, 16'sd990, 1'b0, 4'd8);
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_out_valid", {31'd0, data_out_tvalid}, 32'd0);
    check("rstmid_in_ready", {31'd0, data_in_tready}, 32'd1);
    check("rstmid_lut_ready", {31'd0, lut_data_load_tready}, 32'd1);
    reset = 1'b0;
    wq.delete();
    lq.delete();
    frame_qpsk();
    wait_words("post_rst", 1);
    pop_check("post_rst", 32'hE4E4E4E4, 1'b1);

    frame_bits(32'hA5C30F96, 4'd0);
    wait_words("bps0", 1);
    pop_check("bps0", 32'hA5C30F96, 1'b1);
    frame_bits(32'h12348ACE, 4'd12);
    wait_words("bps12", 1);
    pop_check("bps12", 32'h12348ACE, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
